note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/note_sequencer_pkg.sv | 35 +++
 rtl/note_ram.sv | 24 ++
 rtl/note_sequencer.sv | 114 +++++++++++
 tb/tb_note_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
// rtl/note_sequencer_pkg.sv - shared state encoding, note constants and key encoder
package note_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REC  = 2'd1,
      ST_PLAY = 2'd2
   } state_t;

   localparam logic [2:0] NOTE_C4 = 3'd0;
   localparam logic [2:0] NOTE_D  = 3'd1;
   localparam logic [2:0] NOTE_E  = 3'd2;
   localparam logic [2:0] NOTE_F  = 3'd3;
   localparam logic [2:0] NOTE_G  = 3'd4;
   localparam logic [2:0] NOTE_A  = 3'd5;
   localparam logic [2:0] NOTE_B  = 3'd6;
   localparam logic [2:0] NOTE_C5 = 3'd7;

   typedef struct packed {
      logic       en;
      logic [2:0] idx;
   } note_t;

   // Ascending scan so the highest set key (C4 on bit 7) is the last to assign.
   function automatic note_t encode_keys(input logic [7:0] keys);
      note_t n;
      n.en  = |keys;
      n.idx = NOTE_C4;
      for (int i = 0; i < 8; i++) begin
         if (keys[i]) n.idx = 3'(7 - i);
      end
      return n;
   endfunction

endpackage

// File: rtl/note_ram.sv
// rtl/note_ram.sv - note slot buffer, synchronous write and asynchronous read
module note_ram
   import note_sequencer_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
)(
   input  logic          CLK,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  note_t         wdata,
   input  logic [AW-1:0] raddr,
   output note_t         rdata
);

   note_t mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - record/playback sequencer for an 8-key tone generator
module note_sequencer
   import note_sequencer_pkg::*;
#(
   parameter  int DEPTH    = 16,
   parameter  int TICK_DIV = 12500000,
   localparam int AW       = $clog2(DEPTH),
   localparam int CW       = AW + 1
)(
   input  logic          CLK,
   input  logic          RESET,
   input  logic [7:0]    sw,
   input  logic          rec_btn,
   input  logic          play_btn,
   output logic [2:0]    note_idx,
   output logic          note_en,
   output logic [1:0]    state,
   output logic [CW-1:0] count,
   output logic          full
);

   localparam int TW = $clog2(TICK_DIV);

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   note_t         note_q, note_d;

   note_t live;
   note_t slot;
   logic  tick;
   logic  is_full;
   logic  last_slot;
   logic  wr_en;

   assign live      = encode_keys(sw);
   assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));
   assign is_full   = (count_q == CW'(DEPTH));
   assign last_slot = ({1'b0, ptr_q} == count_q - CW'(1));
   assign wr_en     = (state_q == ST_REC) && tick && !is_full;

   always_ff @(posedge CLK) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (rec_btn)                                state_d = ST_REC;
            else if (play_btn && count_q != '0)         state_d = ST_PLAY;
         end
         ST_REC: begin
            if (rec_btn || is_full)                     state_d = ST_IDLE;
         end
         ST_PLAY: begin
            if (play_btn || (tick && last_slot))        state_d = ST_IDLE;
         end
         default:                                       state_d = ST_IDLE;
      endcase
   end

   // Playback reads at the next pointer so the slot appears on the same edge
   // that enters PLAY or advances, and a live rest shows on the edge that leaves.
   always_comb begin
      note_d = live;
      if (state_d == ST_PLAY) note_d = slot;
   end

   always_comb begin
      tick_cnt_d = tick_cnt_q + TW'(1);
      if (state_d != state_q || tick) tick_cnt_d = '0;

      count_d = count_q;
      if (state_q == ST_IDLE && state_d == ST_REC) count_d = '0;
      else if (wr_en)                              count_d = count_q + CW'(1);

      ptr_d = ptr_q;
      if (state_d != ST_PLAY)                      ptr_d = '0;
      else if (state_q == ST_PLAY && tick)         ptr_d = ptr_q + AW'(1);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         count_q    <= '0;
         ptr_q      <= '0;
         tick_cnt_q <= '0;
         note_q     <= '0;
      end else begin
         count_q    <= count_d;
         ptr_q      <= ptr_d;
         tick_cnt_q <= tick_cnt_d;
         note_q     <= note_d;
      end
   end

   note_ram #(.DEPTH(DEPTH)) u_ram (
      .CLK   (CLK),
      .we    (wr_en),
      .waddr (count_q[AW-1:0]),
      .wdata (live),
      .raddr (ptr_d),
      .rdata (slot)
   );

   assign note_idx = note_q.idx;
   assign note_en  = note_q.en;
   assign state    = state_q;
   assign count    = count_q;
   assign full     = is_full;

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer with DEPTH=4, TICK_DIV=4
module tb_note_sequencer;

   localparam logic [4:0] M_IDX = 5'b10000;
   localparam logic [4:0] M_EN  = 5'b01000;
   localparam logic [4:0] M_ST  = 5'b00100;
   localparam logic [4:0] M_CNT = 5'b00010;
   localparam logic [4:0] M_FL  = 5'b00001;
   localparam logic [4:0] M_ALL = 5'b11111;

   typedef struct {
      int         cyc;
      logic [9:0] val;
      logic [9:0] mask;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] sw;
   logic       rec_btn;
   logic       play_btn;
   logic [2:0] note_idx;
   logic       note_en;
   logic [1:0] state;
   logic [2:0] count;
   logic       full;

   int    cyc   = 0;
   int    total = 0;
   int    bad   = 0;
   exp_t  exp_q[$];
   string name_q[$];

   note_sequencer #(.DEPTH(4), .TICK_DIV(4)) dut (
      .CLK      (clk),
      .RESET    (reset),
      .sw       (sw),
      .rec_btn  (rec_btn),
      .play_btn (play_btn),
      .note_idx (note_idx),
      .note_en  (note_en),
      .state    (state),
      .count    (count),
      .full     (full)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_at(input int dc, input string nm, input logic [2:0] idx, input logic en,
                            input logic [1:0] st, input logic [2:0] cnt, input logic fl, input logic [4:0] m);
      exp_t e;
      e.cyc  = cyc + dc;
      e.val  = {idx, en, st, cnt, fl};
      e.mask = {{3{m[4]}}, m[3], {2{m[2]}}, {3{m[1]}}, m[0]};
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   exp_t       mon_e;
   string      mon_nm;
   logic [9:0] mon_act;

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         mon_e   = exp_q.pop_front();
         mon_nm  = name_q.pop_front();
         mon_act = {note_idx, note_en, state, count, full};
         total++;
         if (((mon_act & mon_e.mask) != (mon_e.val & mon_e.mask)) || mon_e.cyc != cyc) begin
            bad++;
            $display("FAIL %s cyc=%0d got idx=%0d en=%0d st=%0d cnt=%0d full=%0d want idx=%0d en=%0d st=%0d cnt=%0d full=%0d (want_cyc=%0d mask=%b)",
                     mon_nm, cyc, note_idx, note_en, state, count, full,
                     mon_e.val[9:7], mon_e.val[6], mon_e.val[5:4], mon_e.val[3:1], mon_e.val[0],
                     mon_e.cyc, mon_e.mask);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d got stuck want finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      reset    = 1'b1;
      sw       = 8'h00;
      rec_btn  = 1'b0;
      play_btn = 1'b0;

      expect_at(5, "reset", 3'd0, 1'b0, 2'd0, 3'd0, 1'b0, M_ALL);
      step(5);

      total++;
      if (state !== 2'd0) begin
         bad++;
         $display("FAIL direct_reset_state got %0d want 0", state);
      end
      total++;
      if (count !== 3'd0) begin
         bad++;
         $display("FAIL direct_reset_count got %0d want 0", count);
      end
      total++;
      if (note_en !== 1'b0) begin
         bad++;
         $display("FAIL direct_reset_en got %0d want 0", note_en);
      end

      // live keys, one cycle latency, priority
      reset = 1'b0;
      sw    = 8'b0010_0000;
      expect_at(1, "live_e", 3'd2, 1'b1, 2'd0, 3'd0, 1'b0, M_IDX | M_EN | M_ST);
      step(1);

      total++;
      if (note_idx !== 3'd2) begin
         bad++;
         $display("FAIL direct_live_idx got %0d want 2", note_idx);
      end
      total++;
      if (note_en !== 1'b1) begin
         bad++;
         $display("FAIL direct_live_en got %0d want 1", note_en);
      end

      sw = 8'b1000_0100;
      expect_at(1, "prio_c4", 3'd0, 1'b1, 2'd0, 3'd0, 1'b0, M_IDX | M_EN);
      step(1);
      sw = 8'b0000_0011;
      expect_at(1, "prio_b", 3'd6, 1'b1, 2'd0, 3'd0, 1'b0, M_IDX | M_EN);
      step(1);
      sw = 8'h00;
      expect_at(1, "live_rest", 3'd0, 1'b0, 2'd0, 3'd0, 1'b0, M_EN | M_ST);
      step(1);

      // record E, rest, G, C5
      rec_btn = 1'b1;
      expect_at(1,  "rec_entry", 3'd0, 1'b0, 2'd1, 3'd0, 1'b0, M_ST | M_CNT | M_FL);
      expect_at(2,  "rec_live",  3'd2, 1'b1, 2'd1, 3'd0, 1'b0, M_IDX | M_EN | M_ST);
      expect_at(5,  "rec_cnt1",  3'd0, 1'b0, 2'd1, 3'd1, 1'b0, M_ST | M_CNT | M_FL);
      expect_at(9,  "rec_cnt2",  3'd0, 1'b0, 2'd1, 3'd2, 1'b0, M_ST | M_CNT);
      expect_at(13, "rec_cnt3",  3'd0, 1'b0, 2'd1, 3'd3, 1'b0, M_ST | M_CNT | M_FL);
      expect_at(17, "rec_full",  3'd0, 1'b0, 2'd1, 3'd4, 1'b1, M_ST | M_CNT | M_FL);
      expect_at(18, "rec_done",  3'd0, 1'b0, 2'd0, 3'd4, 1'b1, M_ST | M_CNT | M_FL);
      step(1);
      rec_btn = 1'b0;
      sw      = 8'b0010_0000;
      step(4);
      sw = 8'h00;
      step(4);
      sw = 8'b0000_1000;
      step(4);
      sw = 8'b0000_0001;
      step(4);
      sw = 8'h00;
      step(2);

      // playback, live keys and rec_btn ignored
      play_btn = 1'b1;
      expect_at(1,  "play_s0",      3'd2, 1'b1, 2'd2, 3'd4, 1'b0, M_IDX | M_EN | M_ST);
      expect_at(4,  "play_s0_hold", 3'd2, 1'b1, 2'd2, 3'd4, 1'b0, M_IDX | M_EN | M_ST);
      expect_at(5,  "play_rest",    3'd0, 1'b0, 2'd2, 3'd4, 1'b0, M_EN | M_ST);
      expect_at(7,  "play_rec_ign", 3'd0, 1'b0, 2'd2, 3'd4, 1'b1, M_ST | M_CNT | M_FL);
      expect_at(8,  "play_rest_hold", 3'd0, 1'b0, 2'd2, 3'd4, 1'b0, M_EN | M_ST);
      expect_at(9,  "play_s2",      3'd4, 1'b1, 2'd2, 3'd4, 1'b0, M_IDX | M_EN | M_ST);
      expect_at(13, "play_s3",      3'd7, 1'b1, 2'd2, 3'd4, 1'b0, M_IDX | M_EN | M_ST);
      expect_at(16, "play_s3_hold", 3'd7, 1'b1, 2'd2, 3'd4, 1'b0, M_IDX | M_EN | M_ST);
      expect_at(17, "play_end",     3'd0, 1'b0, 2'd0, 3'd4, 1'b0, M_EN | M_ST | M_CNT);
      step(1);
      play_btn = 1'b0;
      step(1);
      sw = 8'hFF;
      step(4);
      rec_btn = 1'b1;
      step(1);
      rec_btn = 1'b0;
      step(7);
      sw = 8'h00;
      step(4);

      // reset on the 2nd tick of playback, then empty-buffer and button rules
      play_btn = 1'b1;
      expect_at(1,  "play2_start",   3'd2, 1'b1, 2'd2, 3'd4, 1'b0, M_IDX | M_EN | M_ST);
      expect_at(9,  "rst_mid_play",  3'd0, 1'b0, 2'd0, 3'd0, 1'b0, M_ALL);
      expect_at(10, "play_cnt0_ign", 3'd0, 1'b0, 2'd0, 3'd0, 1'b0, M_ST | M_CNT);
      expect_at(11, "both_btn_rec",  3'd0, 1'b0, 2'd1, 3'd0, 1'b0, M_ST);
      expect_at(12, "play_in_rec",   3'd0, 1'b0, 2'd1, 3'd0, 1'b0, M_ST);
      expect_at(13, "rec_exit",      3'd0, 1'b0, 2'd0, 3'd0, 1'b0, M_ST | M_CNT | M_FL);
      step(1);
      play_btn = 1'b0;
      step(7);
      reset   = 1'b1;
      rec_btn = 1'b1;
      step(1);
      reset    = 1'b0;
      rec_btn  = 1'b0;
      play_btn = 1'b1;
      step(1);
      rec_btn = 1'b1;
      step(1);
      rec_btn = 1'b0;
      step(1);
      play_btn = 1'b0;
      rec_btn  = 1'b1;
      step(1);
      rec_btn = 1'b0;
      step(3);

      while (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL %s never checked got none want cyc=%0d", name_q[0], exp_q[0].cyc);
         void'(exp_q.pop_front());
         void'(name_q.pop_front());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
